// File: rtl/ifft8_pkg.sv
// Shared constants, state encoding, twiddle lookup and butterfly schedule for the
// streaming 8-point inverse FFT (ifft8_stream).
package ifft8_pkg;

   localparam int DW    = 32;
   localparam int TW_W  = 16;
   localparam int GUARD = 4;
   localparam int IW    = DW + GUARD;

   localparam logic signed [TW_W-1:0] C45    = 16'sd23170;
   localparam logic        [TW_W-1:0] TW_ONE = {1'b0, {(TW_W-1){1'b1}}};

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_UNLOAD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] addr_a;
      logic [2:0] addr_b;
      logic [1:0] m;
   } sched_t;

   // {re, im} of e^{+j*2*pi*m/8}; entries 0 and 2 are nominal, the butterfly treats them exactly
   function automatic logic [2*TW_W-1:0] tw(input logic [1:0] m);
      case (m)
         2'd0:    tw = {TW_ONE, {TW_W{1'b0}}};
         2'd1:    tw = {C45, C45};
         2'd2:    tw = {{TW_W{1'b0}}, TW_ONE};
         default: tw = {-C45, C45};
      endcase
   endfunction

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   // Stage s = idx/4, span 2^s, twiddle index m = j*(4>>s)
   function automatic sched_t sched(input logic [3:0] idx);
      case (idx)
         4'd0:    sched = {3'd0, 3'd1, 2'd0};
         4'd1:    sched = {3'd2, 3'd3, 2'd0};
         4'd2:    sched = {3'd4, 3'd5, 2'd0};
         4'd3:    sched = {3'd6, 3'd7, 2'd0};
         4'd4:    sched = {3'd0, 3'd2, 2'd0};
         4'd5:    sched = {3'd1, 3'd3, 2'd2};
         4'd6:    sched = {3'd4, 3'd6, 2'd0};
         4'd7:    sched = {3'd5, 3'd7, 2'd2};
         4'd8:    sched = {3'd0, 3'd4, 2'd0};
         4'd9:    sched = {3'd1, 3'd5, 2'd1};
         4'd10:   sched = {3'd2, 3'd6, 2'd2};
         4'd11:   sched = {3'd3, 3'd7, 2'd3};
         default: sched = '0;
      endcase
   endfunction

   // Clamp an IW-wide value to the DW signed range; MSB of the result flags a clamp
   function automatic logic [DW:0] sat(input logic signed [IW-1:0] v);
      logic [IW-DW:0] top;
      top = v[IW-1:DW-1];
      if ((&top) || !(|top)) return {1'b0, v[DW-1:0]};
      return {1'b1, v[IW-1], {(DW-1){!v[IW-1]}}};
   endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// Combinational radix-2 butterfly: x = A + B*W, y = A - B*W with W = e^{+j*2*pi*m/8}.
// W0 and W2 are exact; W1/W3 products are rounded half-up individually.
module ifft8_bfly
   import ifft8_pkg::*;
(
   input  logic signed [IW-1:0] a_re_i,
   input  logic signed [IW-1:0] a_im_i,
   input  logic signed [IW-1:0] b_re_i,
   input  logic signed [IW-1:0] b_im_i,
   input  logic        [1:0]    m_i,
   output logic signed [IW-1:0] x_re_o,
   output logic signed [IW-1:0] x_im_o,
   output logic signed [IW-1:0] y_re_o,
   output logic signed [IW-1:0] y_im_o
);

   localparam int PW = IW + TW_W;
   localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W-2);

   function automatic logic signed [IW-1:0] rmul(input logic signed [IW-1:0] x,
                                                 input logic signed [TW_W-1:0] w);
      logic signed [PW-1:0] p;
      p = x * w;
      p = (p + RND) >>> (TW_W-1);
      return p[IW-1:0];
   endfunction

   logic        [2*TW_W-1:0] w;
   logic signed [TW_W-1:0]   w_re, w_im;
   logic signed [IW-1:0]     t_re, t_im;

   always_comb begin
      w    = tw(m_i);
      w_re = w[2*TW_W-1:TW_W];
      w_im = w[TW_W-1:0];
      t_re = b_re_i;
      t_im = b_im_i;
      if (m_i == 2'd2) begin
         t_re = -b_im_i;
         t_im = b_re_i;
      end else if (m_i[0]) begin
         t_re = rmul(b_re_i, w_re) - rmul(b_im_i, w_im);
         t_im = rmul(b_re_i, w_im) + rmul(b_im_i, w_re);
      end
      x_re_o = a_re_i + t_re;
      x_im_o = a_im_i + t_im;
      y_re_o = a_re_i - t_re;
      y_im_o = a_im_i - t_im;
   end

endmodule

// File: rtl/ifft8_stream.sv
// Streaming 8-point inverse FFT: load 8 bins (bit-reversed), 12 in-place butterflies, unload.
// Define IFFT8_SCALE_EN to apply the 1/8 normalisation (round half up) before saturation.
module ifft8_stream
   import ifft8_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          out_last,
   output logic          out_sat
);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic signed [IW-1:0] buf_re_q [8];
   logic signed [IW-1:0] buf_im_q [8];
   logic                 load_we, bfly_we;
   sched_t               sch;
   logic signed [IW-1:0] x_re, x_im, y_re, y_im;

   assign sch = sched(cnt_q);

   ifft8_bfly u_bfly (
      .a_re_i (buf_re_q[sch.addr_a]),
      .a_im_i (buf_im_q[sch.addr_a]),
      .b_re_i (buf_re_q[sch.addr_b]),
      .b_im_i (buf_im_q[sch.addr_b]),
      .m_i    (sch.m),
      .x_re_o (x_re),
      .x_im_o (x_im),
      .y_re_o (y_re),
      .y_im_o (y_im)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load_we   = 1'b0;
      bfly_we   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_we = 1'b1;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  state_d = ST_COMPUTE;
                  cnt_d   = '0;
               end
            end
         end
         ST_COMPUTE: begin
            bfly_we = 1'b1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd11) begin
               state_d = ST_UNLOAD;
               cnt_d   = '0;
            end
         end
         ST_UNLOAD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  state_d = ST_LOAD;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Frame buffer carries no reset: a new frame always overwrites all 8 entries
   always_ff @(posedge clk) begin
      if (load_we) begin
         buf_re_q[bitrev3(cnt_q[2:0])] <= {{GUARD{in_re[DW-1]}}, in_re};
         buf_im_q[bitrev3(cnt_q[2:0])] <= {{GUARD{in_im[DW-1]}}, in_im};
      end
      if (bfly_we) begin
         buf_re_q[sch.addr_a] <= x_re;
         buf_im_q[sch.addr_a] <= x_im;
         buf_re_q[sch.addr_b] <= y_re;
         buf_im_q[sch.addr_b] <= y_im;
      end
   end

   function automatic logic signed [IW-1:0] scale(input logic signed [IW-1:0] v);
`ifdef IFFT8_SCALE_EN
      return (v + IW'(4)) >>> 3;
`else
      return v;
`endif
   endfunction

   logic [DW:0] res_re, res_im;

   always_comb begin
      res_re   = sat(scale(buf_re_q[cnt_q[2:0]]));
      res_im   = sat(scale(buf_im_q[cnt_q[2:0]]));
      out_re   = out_valid ? res_re[DW-1:0] : '0;
      out_im   = out_valid ? res_im[DW-1:0] : '0;
      out_sat  = out_valid & (res_re[DW] | res_im[DW]);
      out_last = out_valid & (cnt_q == 4'd7);
   end

endmodule

// File: tb/tb_ifft8_stream.sv
// Scoreboard bench for ifft8_stream: a direct IDFT model pushes expected samples at frame issue,
// an independent monitor pops and compares on every output handshake.
module tb_ifft8_stream;

   localparam int W  = 32;
   localparam int EW = 8 + 1 + 1 + 2*W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_re = '0;
   logic [W-1:0] in_im = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_re, out_im;
   logic         out_last, out_sat;

   int           n_vec = 0;
   int           n_bad = 0;
   int           cyc   = 0;
   bit           rdy_mode = 1'b0;
   logic [W-1:0] fr_re [8];
   logic [W-1:0] fr_im [8];
   logic [EW-1:0] exp_q[$];

   ifft8_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_last  (out_last),
      .out_sat   (out_sat)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Twiddle values as the hardware defines them: exact 0/+-1, +-c45 = 23170/2^15 for odd angles
   function automatic real qtw(input real v);
      real a;
      a = (v < 0.0) ? -v : v;
      if (a > 0.5 && a < 0.9) return (v < 0.0) ? -23170.0/32768.0 : 23170.0/32768.0;
      if (a >= 0.9)           return (v < 0.0) ? -1.0 : 1.0;
      return 0.0;
   endfunction

   task automatic push_model(input int tol);
      real    pi, vr, vi, ang, c, s, xr, xi;
      longint rr, ri;
      bit     st;
      pi = 3.14159265358979323846;
      for (int n = 0; n < 8; n++) begin
         vr = 0.0;
         vi = 0.0;
         for (int k = 0; k < 8; k++) begin
            ang = 2.0 * pi * real'(k * n) / 8.0;
            c   = qtw($cos(ang));
            s   = qtw($sin(ang));
            xr  = real'($signed(fr_re[k]));
            xi  = real'($signed(fr_im[k]));
            vr  = vr + xr * c - xi * s;
            vi  = vi + xr * s + xi * c;
         end
`ifdef IFFT8_SCALE_EN
         vr = vr / 8.0;
         vi = vi / 8.0;
`endif
         rr = longint'($floor(vr + 0.5));
         ri = longint'($floor(vi + 0.5));
         st = 1'b0;
         if (rr >  64'sd2147483647) begin rr =  64'sd2147483647; st = 1'b1; end
         if (rr < -64'sd2147483648) begin rr = -64'sd2147483648; st = 1'b1; end
         if (ri >  64'sd2147483647) begin ri =  64'sd2147483647; st = 1'b1; end
         if (ri < -64'sd2147483648) begin ri = -64'sd2147483648; st = 1'b1; end
         exp_q.push_back({8'(tol), st, (n == 7), 32'(rr), 32'(ri)});
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_frame();
      for (int k = 0; k < 8; k++) begin
         fr_re[k] = '0;
         fr_im[k] = '0;
      end
   endtask

   task automatic rand_frame();
      for (int k = 0; k < 8; k++) begin
         fr_re[k] = 32'($urandom_range(0, 32'h1000_0000)) - 32'h0800_0000;
         fr_im[k] = 32'($urandom_range(0, 32'h1000_0000)) - 32'h0800_0000;
      end
   endtask

   task automatic send_frame(input bit expect_it, input int tol);
      int wait_cnt;
      if (expect_it) push_model(tol);
      for (int k = 0; k < 8; k++) begin
         if (rdy_mode && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_re    = fr_re[k];
         in_im    = fr_im[k];
         #1;
         wait_cnt = 0;
         while (!in_ready && wait_cnt < 400) begin
            @(negedge clk);
            #1;
            wait_cnt++;
         end
         chk(in_ready == 1'b1, "in_ready_wait", wait_cnt, 400);
      end
   endtask

   always begin
      @(negedge clk);
      out_ready = rdy_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   logic [W-1:0]  h_re, h_im;
   logic          h_last, h_sat;
   bit            held = 1'b0;
   bit            lat_armed = 1'b0;
   int            acc_n = 0;
   int            acc_cyc = 0;
   logic [EW-1:0] e;
   longint        d_re, d_im;
   int            tol;

   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         held      = 1'b0;
         lat_armed = 1'b0;
         acc_n     = 0;
      end else begin
         if (in_valid && in_ready) begin
            acc_n++;
            if (acc_n == 8) begin
               acc_n     = 0;
               acc_cyc   = cyc;
               lat_armed = 1'b1;
            end
         end
         if (held) begin
            chk(out_valid == 1'b1, "stall_valid", out_valid, 1);
            chk(out_re == h_re && out_im == h_im && out_last == h_last && out_sat == h_sat,
                "stall_hold", {out_last, out_sat, out_re}, {h_last, h_sat, h_re});
         end
         held = 1'b0;
         if (out_valid) begin
            if (lat_armed) begin
               chk(cyc - acc_cyc == 13, "latency", cyc - acc_cyc, 13);
               lat_armed = 1'b0;
            end
            chk(in_ready == 1'b0, "in_ready_unload", in_ready, 0);
            if (out_ready) begin
               chk(exp_q.size() > 0, "beat_expected", exp_q.size(), 1);
               if (exp_q.size() > 0) begin
                  e    = exp_q.pop_front();
                  tol  = int'(e[EW-1 -: 8]);
                  d_re = longint'($signed(out_re)) - longint'($signed(e[2*W-1:W]));
                  d_im = longint'($signed(out_im)) - longint'($signed(e[W-1:0]));
                  if (d_re < 0) d_re = -d_re;
                  if (d_im < 0) d_im = -d_im;
                  chk(d_re <= tol, "out_re", $signed(out_re), $signed(e[2*W-1:W]));
                  chk(d_im <= tol, "out_im", $signed(out_im), $signed(e[W-1:0]));
                  chk(out_last == e[2*W], "out_last", out_last, e[2*W]);
                  chk(out_sat == e[2*W+1], "out_sat", out_sat, e[2*W+1]);
               end
            end else begin
               held   = 1'b1;
               h_re   = out_re;
               h_im   = out_im;
               h_last = out_last;
               h_sat  = out_sat;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk(in_ready == 1'b1,  "rst_in_ready",  in_ready,  1);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(out_last == 1'b0,  "rst_out_last",  out_last,  0);
      chk(out_sat == 1'b0,   "rst_out_sat",   out_sat,   0);
      chk(out_re == '0,      "rst_out_re",    out_re,    0);
      chk(out_im == '0,      "rst_out_im",    out_im,    0);
      @(negedge clk);
      rst = 1'b0;

      clear_frame();
      fr_re[0] = 32'h0008_0000;
      send_frame(1'b1, 0);

      clear_frame();
      for (int k = 0; k < 8; k++) fr_re[k] = 32'h0001_0000;
      send_frame(1'b1, 0);

      clear_frame();
      fr_re[1] = 32'h0008_0000;
      send_frame(1'b1, 2);

      clear_frame();
      for (int k = 0; k < 8; k++) fr_re[k] = 32'h7FFF_0000;
      send_frame(1'b1, 0);

      // Frame abandoned by a reset while the butterflies are running
      rand_frame();
      send_frame(1'b0, 0);
      repeat (4) @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #2;
         chk(out_valid == 1'b0, "rst_mid_out_valid", out_valid, 0);
      end
      chk(in_ready == 1'b1, "rst_mid_in_ready", in_ready, 1);
      rst = 1'b0;

      clear_frame();
      fr_re[0] = 32'h0008_0000;
      send_frame(1'b1, 0);

      rdy_mode = 1'b1;
      for (int f = 0; f < 6; f++) begin
         rand_frame();
         send_frame(1'b1, 4);
      end

      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
      chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
